// File: rtl/pulse_on_change.sv
// pulse_on_change: emits a one-clock pulse on x for every change of the
// asynchronous multi-bit input a.
//
// a is brought into the clk domain through a per-bit flop chain. The last
// stage is compared against its value from the previous cycle. Any bit
// difference produces a registered, glitch-free pulse.
//
// x is held low until the synchronizer has filled with real samples after
// reset. This prevents a spurious pulse from the reset value.
//
// Parameters:
//   WIDTH       - bit width of a (>= 1)
//   SYNC_STAGES - synchronizer flops per bit (>= 2)
//
// Ports:
//   clk - system clock; all state updates on its rising edge
//   rst - asynchronous active-low reset
//   a   - monitored value, asynchronous to clk
//   x   - change pulse, registered, active-high
module pulse_on_change #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    output logic             x
);

    // The counter must hold 0..SYNC_STAGES, so it needs clog2(SYNC_STAGES+1) bits.
    localparam int unsigned     CntW   = $clog2(SYNC_STAGES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(SYNC_STAGES);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_w;
    logic [WIDTH-1:0] prev_q;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             primed_q, primed_d;
    logic             x_q, x_d;

    // Synchronizer chain: stage 0 samples a, each later stage samples the one before it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= a;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_w = sync_q[SYNC_STAGES-1];

    // Priming bookkeeping and change detection.
    always_comb begin
        cnt_d    = cnt_q;
        primed_d = primed_q;
        x_d      = 1'b0;

        if (!primed_q) begin
            // primed rises on edge SYNC_STAGES+1 after reset release. From the
            // edge after that onward, both sync and prev hold values sampled
            // from a rather than reset values.
            if (cnt_q == CntMax) begin
                primed_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else begin
            x_d = (sync_w != prev_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q   <= '0;
            cnt_q    <= '0;
            primed_q <= 1'b0;
            x_q      <= 1'b0;
        end else begin
            prev_q   <= sync_w;
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            x_q      <= x_d;
        end
    end

    assign x = x_q;

endmodule

// File: tb/tb_pulse_on_change.sv
// Testbench for pulse_on_change. This bench uses randomized and directed stimulus.
// It compares the DUT against a behavioural model built from the sampled history of a.
//
// Model: let s_k be the value of a at the k-th rising edge after reset release.
// After edge k, x = (s_{k-S} != s_{k-S-1}) when k >= S+2, and x = 0 otherwise.
module tb_pulse_on_change;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned S     = 2;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic             x;

    int checks   = 0;
    int failures = 0;

    // Edge-accurate history of a since the last reset release.
    logic [WIDTH-1:0] hist[$];
    int pulse_cnt = 0;   // DUT pulses observed
    int model_cnt = 0;   // pulses the model expects

    pulse_on_change #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (S)
    ) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .x   (x)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Per-edge reference model and comparison.
    initial begin : monitor
        int k;
        logic exp_x;
        forever begin
            @(posedge clk);
            if (rst) hist.push_back(a);
            else     hist.delete();
            #1;
            k = hist.size();
            exp_x = 1'b0;
            if (rst && k >= S + 2) exp_x = (hist[k-S-1] != hist[k-S-2]);
            check_eq("x_model", {31'd0, x}, {31'd0, exp_x});
            if (x === 1'b1) pulse_cnt++;
            if (exp_x) model_cnt++;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation timeout, got running, expected finished");
        $fatal(1, "timeout");
    end

    // Places a change at a random time that never lands exactly on a rising edge.
    task automatic rand_wait(input int unsigned max_ns);
        #($urandom_range(0, max_ns));
        if ($time % 10 == 5) #1;
    endtask

    initial begin : stim
        bit seen;

        // Hold reset with a = 0, then release and idle.
        rst = 1'b0;
        a   = '0;
        #10;
        rst = 1'b1;
        #1 check_eq("reset_x", {31'd0, x}, 32'd0);
        pulse_cnt = 0;
        repeat (20) @(posedge clk);
        #2 check_eq("idle_pulses", pulse_cnt, 0);

        // Reset, then release with a nonzero value held: priming must hide it.
        @(posedge clk); #3;
        rst = 1'b0;
        a   = 8'h5A;
        #1 check_eq("in_reset_x", {31'd0, x}, 32'd0);
        #10;
        rst = 1'b1;
        pulse_cnt = 0;
        repeat (10) @(posedge clk);
        #2 check_eq("prime_nonzero_pulses", pulse_cnt, 0);

        // Settle at 0. The change from 0x5A to 0 gives one pulse.
        a = 8'h00;
        repeat (6) @(posedge clk);
        #2 check_eq("settle_pulses", pulse_cnt, 1);

        // Single change just after an edge: x is high for exactly the 3rd edge.
        @(posedge clk); #2;
        a = 8'h01;
        repeat (2) begin
            @(posedge clk); #1 check_eq("lat_early", {31'd0, x}, 32'd0);
        end
        @(posedge clk); #1 check_eq("lat_pulse", {31'd0, x}, 32'd1);
        @(posedge clk); #1 check_eq("lat_after", {31'd0, x}, 32'd0);

        // Increment every 30 ns for 25 steps.
        @(posedge clk); #2;
        pulse_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            a = a + 8'd1;
            #30;
        end
        repeat (5) @(posedge clk);
        #2 check_eq("inc30_pulses", pulse_cnt, 25);

        // Increment before every edge: a continuous run of pulses.
        pulse_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #2;
            a = a + 8'd1;
        end
        repeat (5) @(posedge clk);
        #2 check_eq("consec_pulses", pulse_cnt, 16);

        // Random values at random spacing of 0 to 47 ns.
        pulse_cnt = 0;
        model_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            rand_wait(47);
            if ($urandom_range(0, 3) == 0) a = a + 8'd1;
            else                           a = WIDTH'($urandom);
        end
        repeat (6) @(posedge clk);
        #2 check_eq("rand_pulse_total", pulse_cnt, model_cnt);

        // Reset while x is high: x must clear at once.
        @(posedge clk); #2;
        a = a ^ 8'h81;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk); #3;
            if (x === 1'b1) seen = 1'b1;
        end
        check_eq("pulse_before_reset", {31'd0, seen}, 32'd1);
        rst = 1'b0;
        #1 check_eq("async_clear_x", {31'd0, x}, 32'd0);
        #12;
        rst = 1'b1;
        pulse_cnt = 0;
        repeat (8) @(posedge clk);
        #2 check_eq("reprime_pulses", pulse_cnt, 0);

        // A change after re-priming is detected normally.
        a = a + 8'd3;
        repeat (6) @(posedge clk);
        #2 check_eq("post_reset_pulses", pulse_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
